sample_feeder: RTL

Sample source for the perceptron training controller. A host fills an on-chip sample store with (x1, x2, t) training tuples. The trainer then pulls one tuple per request. The block flags the last tuple of an epoch with `eof` and rewinds to tuple 0 when the trainer starts a new epoch. It is the read-side counterpart of the trainer's reading/waiting/reseting sequence and sits between the host load path and the trainer datapath registers.

---
 rtl/perceptron_pkg.sv | 21 ++
 rtl/sample_ram.sv | 34 +++
 rtl/sample_feeder.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/perceptron_pkg.sv
// Shared types for the perceptron trainer and its sample feeder.
// Holds the default sample width, the feeder state encoding and the training tuple layout.
package perceptron_pkg;

    localparam int unsigned SAMPLE_DW = 8;

    typedef enum logic [2:0] {
        StEmpty,
        StLoading,
        StReady,
        StFetch,
        StPresent
    } feeder_state_e;

    typedef struct packed {
        logic signed [SAMPLE_DW-1:0] x1;
        logic signed [SAMPLE_DW-1:0] x2;
        logic                        t;
    } tuple_t;

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port tuple store: synchronous write, registered synchronous read.
// Contents are deliberately not reset.
module sample_ram #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sample_feeder.sv
// Training tuple source: host loads (x1, x2, t) tuples, trainer fetches one per request.
// Optional epoch counter output enabled by defining SAMPLE_FEEDER_EPOCH_CNT_EN.
module sample_feeder
    import perceptron_pkg::*;
#(
    parameter int unsigned DW    = SAMPLE_DW,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_start,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic signed [DW-1:0] wr_x1,
    input  logic signed [DW-1:0] wr_x2,
    input  logic                 wr_t,
    input  logic                 wr_last,
    input  logic                 rd_req,
    input  logic                 rewind,
    output logic                 rd_valid,
    output logic signed [DW-1:0] x1,
    output logic signed [DW-1:0] x2,
    output logic                 t,
    output logic                 eof,
    output logic                 rd_err,
    output logic [AW:0]          count,
    output logic                 full
`ifdef SAMPLE_FEEDER_EPOCH_CNT_EN
    ,
    output logic [15:0]          epochs
`endif
);

    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = 2 * DW + 1;

    feeder_state_e state_q, state_d;
    logic [AW:0]          count_q, count_d;
    logic [AW-1:0]        ptr_q, ptr_d;
    logic                 full_q, full_d;
    logic                 eof_pend_q, eof_pend_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 rd_err_q, rd_err_d;
    logic signed [DW-1:0] x1_q, x1_d;
    logic signed [DW-1:0] x2_q, x2_d;
    logic                 t_q, t_d;
    logic                 eof_q, eof_d;

    logic          ram_we;
    logic          ram_re;
    logic [TW-1:0] ram_rdata;
    logic [AW:0]   ptr_inc;
    logic [AW-1:0] ptr_wrap;
    logic          ptr_is_last;
    logic          load_accept;

    sample_ram #(
        .WIDTH (TW),
        .DEPTH (DEPTH)
    ) u_sample_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (count_q[AW-1:0]),
        .wdata ({wr_x1, wr_x2, wr_t}),
        .re    (ram_re),
        .raddr (ptr_q),
        .rdata (ram_rdata)
    );

    assign ptr_inc     = {1'b0, ptr_q} + CW'(1);
    assign ptr_wrap    = (ptr_inc == count_q) ? '0 : ptr_inc[AW-1:0];
    assign ptr_is_last = ({1'b0, ptr_q} == (count_q - CW'(1)));
    assign load_accept = load_start && (state_q inside {StEmpty, StReady, StPresent});

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        ptr_d      = ptr_q;
        full_d     = full_q;
        eof_pend_d = eof_pend_q;
        x1_d       = x1_q;
        x2_d       = x2_q;
        t_d        = t_q;
        eof_d      = eof_q;
        rd_valid_d = 1'b0;
        rd_err_d   = rd_req && (state_q != StReady);
        ram_we     = 1'b0;
        ram_re     = 1'b0;

        unique case (state_q)
            StEmpty: begin
                if (rewind) begin
                    ptr_d = '0;
                end
            end
            StLoading: begin
                if (wr_valid) begin
                    ram_we  = 1'b1;
                    count_d = count_q + CW'(1);
                    if (wr_last) begin
                        state_d = StReady;
                    end else if (count_q == CW'(DEPTH - 1)) begin
                        state_d = StReady;
                        full_d  = 1'b1;
                    end
                end
            end
            StReady: begin
                // Rewind lands before the read address is used, so a same-cycle
                // request fetches tuple 0.
                if (rewind) begin
                    ptr_d = '0;
                end
                if (rd_req) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                ram_re     = 1'b1;
                eof_pend_d = ptr_is_last;
                ptr_d      = rewind ? '0 : ptr_wrap;
                state_d    = StPresent;
            end
            StPresent: begin
                {x1_d, x2_d, t_d} = ram_rdata;
                eof_d      = eof_pend_q;
                rd_valid_d = 1'b1;
                if (rewind) begin
                    ptr_d = '0;
                end
                state_d = StReady;
            end
            default: begin
                state_d = StEmpty;
            end
        endcase

        if (load_accept) begin
            state_d = StLoading;
            count_d = '0;
            full_d  = 1'b0;
            ptr_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StEmpty;
            count_q    <= '0;
            ptr_q      <= '0;
            full_q     <= 1'b0;
            eof_pend_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            x1_q       <= '0;
            x2_q       <= '0;
            t_q        <= 1'b0;
            eof_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            ptr_q      <= ptr_d;
            full_q     <= full_d;
            eof_pend_q <= eof_pend_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            x1_q       <= x1_d;
            x2_q       <= x2_d;
            t_q        <= t_d;
            eof_q      <= eof_d;
        end
    end

`ifdef SAMPLE_FEEDER_EPOCH_CNT_EN
    logic [15:0] epochs_q, epochs_d;

    always_comb begin
        epochs_d = epochs_q;
        if (load_accept) begin
            epochs_d = '0;
        end else if (rewind && (state_q != StLoading) && (epochs_q != 16'hFFFF)) begin
            epochs_d = epochs_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            epochs_q <= '0;
        end else begin
            epochs_q <= epochs_d;
        end
    end

    assign epochs = epochs_q;
`endif

    assign wr_ready = (state_q == StLoading);
    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;
    assign x1       = x1_q;
    assign x2       = x2_q;
    assign t        = t_q;
    assign eof      = eof_q;
    assign count    = count_q;
    assign full     = full_q;

endmodule
